// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Optional feature macro: FETCH_PERF_CNT_EN (performance counters).
package fetch_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int SEXT_W     = 17;
    localparam int TGT_W      = 27;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        HALT  = 2'd3
    } state_t;

    // Sign-extend the branch offset field N to a full word.
    function automatic logic [31:0] sext_n(input logic [SEXT_W-1:0] n);
        return {{(32-SEXT_W){n[SEXT_W-1]}}, n};
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction, decoder strobes, datapath flags and fetch outputs.
// Perf counter signals exist only when FETCH_PERF_CNT_EN is defined.
interface fetch_if #(
    parameter int ADDR_W = 12
);

    logic [31:0]       q_imem;
    logic              jp;
    logic              jal;
    logic              jr;
    logic              bne;
    logic              blt;
    logic              bex;
    logic [31:0]       jr_target;
    logic              alu_ne;
    logic              alu_lt;
    logic              rstatus_nz;
    logic              stall_req;
    logic              stall_done;
    logic [ADDR_W-1:0] address_imem;
    logic [31:0]       pc_plus1;
    logic              fetch_valid;
    logic              halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]       perf_fetched;
    logic [31:0]       perf_redirects;
`endif

    modport master (
        input  q_imem, jp, jal, jr, bne, blt, bex, jr_target,
        input  alu_ne, alu_lt, rstatus_nz, stall_req, stall_done,
`ifdef FETCH_PERF_CNT_EN
        output perf_fetched, perf_redirects,
`endif
        output address_imem, pc_plus1, fetch_valid, halted
    );

    modport slave (
        output q_imem, jp, jal, jr, bne, blt, bex, jr_target,
        output alu_ne, alu_lt, rstatus_nz, stall_req, stall_done,
`ifdef FETCH_PERF_CNT_EN
        input  perf_fetched, perf_redirects,
`endif
        input  address_imem, pc_plus1, fetch_valid, halted
    );

endinterface

// File: rtl/fetch_unit_next_pc_sel.sv
// Combinational next-PC selection: priority redirect mux plus PC adders.
// Also flags a jump-to-self (halt) and any departure from sequential flow.
module next_pc_sel
    import fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [31:0]       q_imem,
    input  logic              jp,
    input  logic              jal,
    input  logic              jr,
    input  logic              bne,
    input  logic              blt,
    input  logic              bex,
    input  logic [31:0]       jr_target,
    input  logic              alu_ne,
    input  logic              alu_lt,
    input  logic              rstatus_nz,
    output logic [ADDR_W-1:0] next_pc,
    output logic [ADDR_W-1:0] pc_inc,
    output logic              redirect,
    output logic              halt_hit
);

    logic [31:0]       n_ext;
    logic [ADDR_W-1:0] tgt;
    logic [ADDR_W-1:0] br_tgt;
    logic              unused_bits;

    assign n_ext  = sext_n(q_imem[SEXT_W-1:0]);
    assign tgt    = q_imem[ADDR_W-1:0];
    assign pc_inc = pc + ADDR_W'(1);
    assign br_tgt = pc_inc + n_ext[ADDR_W-1:0];

    assign unused_bits = ^{q_imem[31:SEXT_W], jr_target[31:ADDR_W],
                           n_ext[31:ADDR_W]};

    // First matching condition wins; overlapping strobes resolve here.
    always_comb begin
        next_pc = pc_inc;
        case (1'b1)
            bex & rstatus_nz: next_pc = tgt;
            jp:               next_pc = tgt;
            jr:               next_pc = jr_target[ADDR_W-1:0];
            bne & alu_ne:     next_pc = br_tgt;
            blt & alu_lt:     next_pc = br_tgt;
            default:          next_pc = pc_inc;
        endcase
    end

    assign redirect = (next_pc != pc_inc);
    assign halt_hit = jp & ~jal & (tgt == pc);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, BOOT/RUN/STALL/HALT FSM, link value.
// Define FETCH_PERF_CNT_EN to add saturating fetched/redirect counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic  clock,
    input  logic  reset,
    fetch_if.master bus
);

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] next_pc;
    logic [ADDR_W-1:0] pc_inc;
    logic              redirect;
    logic              halt_hit;
    logic              fetch_valid;
    logic              halted;

    next_pc_sel #(
        .ADDR_W (ADDR_W)
    ) u_sel (
        .pc         (pc),
        .q_imem     (bus.q_imem),
        .jp         (bus.jp),
        .jal        (bus.jal),
        .jr         (bus.jr),
        .bne        (bus.bne),
        .blt        (bus.blt),
        .bex        (bus.bex),
        .jr_target  (bus.jr_target),
        .alu_ne     (bus.alu_ne),
        .alu_lt     (bus.alu_lt),
        .rstatus_nz (bus.rstatus_nz),
        .next_pc    (next_pc),
        .pc_inc     (pc_inc),
        .redirect   (redirect),
        .halt_hit   (halt_hit)
    );

    // FSM and PC update with registered fetch_valid/halted outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= BOOT;
            pc          <= '0;
            fetch_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            unique case (state)
                BOOT: begin
                    state       <= RUN;
                    fetch_valid <= 1'b1;
                end
                RUN: begin
                    if (bus.stall_req) begin
                        state       <= STALL;
                        fetch_valid <= 1'b0;
                    end else if (halt_hit) begin
                        state       <= HALT;
                        fetch_valid <= 1'b0;
                        halted      <= 1'b1;
                    end else begin
                        pc <= next_pc;
                    end
                end
                STALL: begin
                    if (bus.stall_done) begin
                        state       <= RUN;
                        pc          <= pc_inc;
                        fetch_valid <= 1'b1;
                    end
                end
                HALT: begin
                    halted <= 1'b1;
                end
                default: begin
                    state       <= BOOT;
                    fetch_valid <= 1'b0;
                    halted      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.address_imem = pc;
    assign bus.pc_plus1     = {{(32-ADDR_W){1'b0}}, pc_inc};
    assign bus.fetch_valid  = fetch_valid;
    assign bus.halted       = halted;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_redirects;

    // Saturating counts of issuing RUN cycles and non-sequential next-PCs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            perf_fetched   <= '0;
            perf_redirects <= '0;
        end else if (state == RUN) begin
            if (!bus.stall_req && perf_fetched != 32'hFFFF_FFFF) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (redirect && perf_redirects != 32'hFFFF_FFFF) begin
                perf_redirects <= perf_redirects + 32'd1;
            end
        end
    end

    assign bus.perf_fetched   = perf_fetched;
    assign bus.perf_redirects = perf_redirects;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic
// compared each cycle with a behavioural PC/mode model.
module tb_fetch_unit;

    localparam int          AW   = 12;
    localparam int unsigned MASK = (1 << AW) - 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fetch_if #(.ADDR_W(AW)) bus ();

    fetch_unit #(.ADDR_W(AW)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // model: PC and mode flags
    int unsigned m_pc;
    bit          m_boot;
    bit          m_stall;
    bit          m_halt;
    int unsigned m_fet;
    int unsigned m_red;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned ref_next();
        int unsigned t;
        int          n;
        logic [16:0] nf;
        t  = bus.q_imem & MASK;
        nf = bus.q_imem[16:0];
        n  = int'($signed(nf));
        if (bus.bex && bus.rstatus_nz) return t;
        if (bus.jp) return t;
        if (bus.jr) return bus.jr_target & MASK;
        if ((bus.bne && bus.alu_ne) || (bus.blt && bus.alu_lt))
            return (m_pc + 1 + n) & MASK;
        return (m_pc + 1) & MASK;
    endfunction

    task automatic tick();
        int unsigned nx;
        int unsigned seq;
        nx  = ref_next();
        seq = (m_pc + 1) & MASK;
        if (!rst) begin
            m_pc = 0; m_boot = 1; m_stall = 0; m_halt = 0;
            m_fet = 0; m_red = 0;
        end else if (m_boot) begin
            m_boot = 0;
        end else if (m_halt) begin
            m_halt = 1;
        end else if (m_stall) begin
            if (bus.stall_done) begin
                m_pc = seq;
                m_stall = 0;
            end
        end else begin
            if (!bus.stall_req && m_fet != 32'hFFFF_FFFF) m_fet++;
            if (nx != seq && m_red != 32'hFFFF_FFFF) m_red++;
            if (bus.stall_req) m_stall = 1;
            else if (bus.jp && !bus.jal && (bus.q_imem & MASK) == m_pc)
                m_halt = 1;
            else m_pc = nx;
        end
        @(posedge clk);
        #1;
        check("addr", 32'(bus.address_imem), m_pc);
        check("valid", 32'(bus.fetch_valid),
              32'(!(m_boot || m_stall || m_halt)));
        check("halted", 32'(bus.halted), 32'(m_halt));
        check("link", bus.pc_plus1, (m_pc + 1) & MASK);
`ifdef FETCH_PERF_CNT_EN
        check("perf_fet", bus.perf_fetched, m_fet);
        check("perf_red", bus.perf_redirects, m_red);
`endif
    endtask

    task automatic clr();
        bus.q_imem = '0; bus.jp = 0; bus.jal = 0; bus.jr = 0;
        bus.bne = 0; bus.blt = 0; bus.bex = 0; bus.jr_target = '0;
        bus.alu_ne = 0; bus.alu_lt = 0; bus.rstatus_nz = 0;
        bus.stall_req = 0; bus.stall_done = 0;
    endtask

    task automatic go_to(input int unsigned a);
        clr();
        bus.jp = 1;
        bus.q_imem = a;
        tick();
        clr();
    endtask

    task automatic rand_in();
        bus.q_imem     = $urandom;
        if ($urandom_range(0, 7) == 0)
            bus.q_imem = {bus.q_imem[31:12], 12'(m_pc)};
        bus.jp         = ($urandom_range(0, 5) == 0);
        bus.jal        = bus.jp && ($urandom_range(0, 2) == 0);
        bus.jr         = ($urandom_range(0, 5) == 0);
        bus.bne        = ($urandom_range(0, 4) == 0);
        bus.blt        = ($urandom_range(0, 4) == 0);
        bus.bex        = ($urandom_range(0, 5) == 0);
        bus.jr_target  = $urandom;
        bus.alu_ne     = $urandom_range(0, 1) == 1;
        bus.alu_lt     = $urandom_range(0, 1) == 1;
        bus.rstatus_nz = $urandom_range(0, 1) == 1;
        bus.stall_req  = ($urandom_range(0, 7) == 0);
        bus.stall_done = ($urandom_range(0, 2) == 0);
    endtask

    initial begin
        int exp_a[4];
        exp_a = '{0, 1, 2, 3};
        clr();
        rst = 1'b0;
        tick();
        tick();
        check("t1_rst_addr", 32'(bus.address_imem), 0);
        check("t1_rst_valid", 32'(bus.fetch_valid), 0);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t1_addr", 32'(bus.address_imem), exp_a[i]);
            check("t1_valid", 32'(bus.fetch_valid), 1);
        end

        go_to(5);
        bus.bne = 1; bus.alu_ne = 1; bus.q_imem = 32'h0001_FFFD;
        tick();
        check("t2_taken", 32'(bus.address_imem), 3);
        go_to(5);
        bus.bne = 1; bus.alu_ne = 0; bus.q_imem = 32'h0001_FFFD;
        tick();
        check("t2_fall", 32'(bus.address_imem), 6);

        go_to(7);
        bus.jp = 1; bus.jal = 1; bus.q_imem = 32'h40;
        check("t3_link", bus.pc_plus1, 8);
        tick();
        check("t3_jal", 32'(bus.address_imem), 32'h40);
        clr();
        bus.jp = 1; bus.bex = 1; bus.rstatus_nz = 1; bus.jr = 1;
        bus.jr_target = 32'h77; bus.q_imem = 32'h123;
        tick();
        check("t3_prio", 32'(bus.address_imem), 32'h123);

        go_to(9);
        bus.stall_req = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.stall_req = 0;
            check("t4_hold", 32'(bus.address_imem), 9);
            check("t4_valid", 32'(bus.fetch_valid), 0);
        end
        bus.stall_done = 1;
        tick();
        clr();
        check("t4_resume", 32'(bus.address_imem), 10);
        check("t4_run", 32'(bus.fetch_valid), 1);

        go_to(32'h20);
        bus.jp = 1; bus.q_imem = 32'h20;
        tick();
        check("t5_halted", 32'(bus.halted), 1);
        for (int i = 0; i < 10; i++) begin
            rand_in();
            tick();
            check("t5_park", 32'(bus.address_imem), 32'h20);
        end
        clr();
        rst = 1'b0;
        tick();
        check("t5_rst_addr", 32'(bus.address_imem), 0);
        check("t5_rst_halt", 32'(bus.halted), 0);
        rst = 1'b1;
        tick();

        go_to(32'h30);
        bus.stall_req = 1;
        tick();
        clr();
        tick();
        rst = 1'b0;
        tick();
        check("t6_rst_addr", 32'(bus.address_imem), 0);
        check("t6_rst_valid", 32'(bus.fetch_valid), 0);
        rst = 1'b1;
        tick();
        go_to(32'hFFF);
        tick();
        check("t6_wrap", 32'(bus.address_imem), 0);

        for (int i = 0; i < 3000; i++) begin
            rand_in();
            rst = ($urandom_range(0, 99) != 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
